// File: rtl/detector_stim_controller.sv
// detector_stim_controller: serialises a stimulus pattern into a Mealy/Moore detector pair and
// counts the detections each one reports, flagging a mismatch between the two counts at completion.
module detector_stim_controller #(
  parameter int PAT_W = 16,
  parameter int CNT_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [4:0]       length,
  input  logic             z_mealy,
  input  logic             z_moore,
  output logic             data_out,
  output logic             step,
  output logic             det_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mealy_count,
  output logic [CNT_W-1:0] moore_count,
  output logic             mismatch
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic [PAT_W-1:0] shreg, shreg_nxt;
  logic [4:0] bitcnt, bitcnt_nxt, eff_len;
  logic [CNT_W-1:0] mealy_nxt, moore_nxt;
  logic mismatch_nxt;
  assign eff_len = (32'(length) > PAT_W) ? 5'(PAT_W) : length;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      mealy_count <= '0;
      moore_count <= '0;
      mismatch    <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bitcnt      <= bitcnt_nxt;
      mealy_count <= mealy_nxt;
      moore_count <= moore_nxt;
      mismatch    <= mismatch_nxt;
    end
  end
  // Outputs decode the registered state, so an asynchronous reset clears them at once.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bitcnt_nxt   = bitcnt;
    mealy_nxt    = mealy_count;
    moore_nxt    = moore_count;
    mismatch_nxt = mismatch;
    step         = state == SHIFT;
    det_clr      = state == LOAD;
    busy         = state != IDLE;
    done         = state == DONE;
    data_out     = (state == SHIFT || state == WAIT) && shreg[PAT_W-1];
    case (state)
      IDLE: if (start) begin
        shreg_nxt    = pattern;
        bitcnt_nxt   = eff_len;
        mealy_nxt    = '0;
        moore_nxt    = '0;
        mismatch_nxt = 1'b0;
        state_nxt    = LOAD;
      end
      LOAD: state_nxt = abort ? IDLE : (bitcnt == '0 ? DONE : SHIFT);
      SHIFT: if (abort) state_nxt = IDLE;
      else begin
        if (z_mealy && mealy_count != {CNT_W{1'b1}}) mealy_nxt = mealy_count + CNT_W'(1);
        state_nxt = WAIT;
      end
      WAIT: if (abort) state_nxt = IDLE;
      else begin
        if (z_moore && moore_count != {CNT_W{1'b1}}) moore_nxt = moore_count + CNT_W'(1);
        shreg_nxt  = {shreg[PAT_W-2:0], 1'b0};
        bitcnt_nxt = bitcnt - 5'd1;
        state_nxt  = bitcnt == 5'd1 ? DONE : SHIFT;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == DONE) mismatch_nxt = mealy_nxt != moore_nxt;
  end
endmodule

// File: tb/tb_detector_stim_controller.sv
// tb_detector_stim_controller: directed runs of the stimulus controller with hand-computed
// cycle positions, serial bits and detection counts.
module tb_detector_stim_controller;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0] length = '0;
  logic z_mealy = 1'b0, z_moore = 1'b0;
  logic data_out, step, det_clr, busy, done, mismatch;
  logic [4:0] mealy_count, moore_count;
  int checks = 0, errors = 0;

  detector_stim_controller dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .length(length), .z_mealy(z_mealy), .z_moore(z_moore), .data_out(data_out),
    .step(step), .det_clr(det_clr), .busy(busy), .done(done),
    .mealy_count(mealy_count), .moore_count(moore_count), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycle c counts edges after the start-sampling edge; bit i is in SHIFT at 2i, WAIT at 2i+1.
  task automatic run_case(input string tag, input logic [15:0] pat, input logic [4:0] len,
                          input logic [15:0] mmask, input logic [15:0] qmask,
                          input int exp_steps, input logic [15:0] exp_bits, input int exp_done,
                          input int exp_mc, input int exp_qc, input logic exp_mm);
    int steps = 0, done_cyc = 0, clr_cyc = 0;
    logic [15:0] bits = '0;
    pattern = pat;
    length = len;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      z_mealy = (c >= 2 && c % 2 == 0 && c / 2 - 1 < 16) ? mmask[c/2-1] : 1'b0;
      z_moore = (c >= 3 && c % 2 == 1 && (c - 3) / 2 < 16) ? qmask[(c-3)/2] : 1'b0;
      if (det_clr && clr_cyc == 0) clr_cyc = c;
      if (step) begin
        steps++;
        bits = {bits[14:0], data_out};
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      tick;
    end
    z_mealy = 1'b0;
    z_moore = 1'b0;
    check({tag, " clr_cycle"}, clr_cyc, 1);
    check({tag, " done_cycle"}, done_cyc, exp_done);
    check({tag, " steps"}, steps, exp_steps);
    check({tag, " bits"}, bits, exp_bits);
    check({tag, " mealy_count"}, mealy_count, exp_mc);
    check({tag, " moore_count"}, moore_count, exp_qc);
    check({tag, " mismatch"}, mismatch, exp_mm);
    tick;
    check({tag, " idle_busy"}, busy, 0);
    check({tag, " idle_done"}, done, 0);
  endtask

  initial begin
    tick;
    tick;
    check("rst outputs", {data_out, step, det_clr, busy, done, mismatch}, 0);
    check("rst counts", {mealy_count, moore_count}, 0);
    reset = 1'b1;
    tick;

    run_case("basic", 16'hB000, 5'd4, 16'h0000, 16'h0000, 4, 16'h000B, 10, 0, 0, 1'b0);
    run_case("counts", 16'hB000, 5'd4, 16'h000A, 16'h0008, 4, 16'h000B, 10, 2, 1, 1'b1);
    tick;
    check("hold mealy", mealy_count, 2);
    check("hold moore", moore_count, 1);
    check("hold mismatch", mismatch, 1);
    run_case("len0", 16'hFFFF, 5'd0, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 2, 0, 0, 1'b0);
    run_case("len20", 16'hA5C3, 5'd20, 16'hFFFF, 16'hFFFF, 16, 16'hA5C3, 34, 16, 16, 1'b0);

    // abort in WAIT of bit 2; a start pulse while busy must not disturb the run
    pattern = 16'hF000;
    length = 5'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    z_mealy = 1'b1;
    tick;
    z_mealy = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("abort step_b2", step, 1);
    tick;
    check("abort in_wait", {step, busy}, 2'b01);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort mealy", mealy_count, 1);
    check("abort mismatch", mismatch, 0);
    tick;
    check("abort no_done", {busy, done}, 0);

    // reset in SHIFT of bit 3, then start on the first edge after release
    z_mealy = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick;
    check("rst_mid shift", {step, data_out}, 2'b11);
    reset = 1'b0;
    #1;
    check("rst_mid outputs", {data_out, step, det_clr, busy, done, mismatch}, 0);
    check("rst_mid counts", {mealy_count, moore_count}, 0);
    z_mealy = 1'b0;
    #1;
    reset = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("post_rst start", {det_clr, busy}, 2'b11);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("post_rst abort", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/detector_stim_controller.md
DETECTOR_STIM_CONTROLLER -- requirements
Module: detector_stim_controller

Interface
REQ-001 SHALL have parameter PAT_W, default 16: pattern register width in bits, at least 2.
REQ-002 SHALL have parameter CNT_W, default $clog2(PAT_W+1): width of the detection counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1 bit: synchronous cancel of a run.
REQ-007 SHALL have port pattern, input, PAT_W bits: stimulus bits, applied MSB first.
REQ-008 SHALL have port length, input, 5 bits: number of bits to apply.
REQ-009 SHALL have port z_mealy, input, 1 bit: Mealy detector output.
REQ-010 SHALL have port z_moore, input, 1 bit: Moore detector output.
REQ-011 SHALL have port data_out, output, 1 bit: serial stimulus to both detectors' data input.
REQ-012 SHALL have port step, output, 1 bit: detector clock enable; one-cycle pulse per applied bit.
REQ-013 SHALL have port det_clr, output, 1 bit: active-high one-cycle clear to both detectors.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse marking run completion.
REQ-016 SHALL have port mealy_count, output, CNT_W bits: number of z_mealy detections in the last run.
REQ-017 SHALL have port moore_count, output, CNT_W bits: number of z_moore detections in the last run.
REQ-018 SHALL have port mismatch, output, 1 bit: high when mealy_count != moore_count, valid from the done pulse.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, SHIFT, WAIT and DONE.
REQ-020 SHALL, in IDLE with start=1, load shreg from pattern, load bitcnt from the effective length, clear both counts and mismatch, and go to LOAD.
REQ-021 SHALL use effective length = min(length, PAT_W); with length=0 it SHALL go IDLE->LOAD->DONE without asserting step.
REQ-022 SHALL hold det_clr=1 for exactly the LOAD cycle; LOAD SHALL go to SHIFT, or to DONE when bitcnt=0.
REQ-023 SHALL, in SHIFT, drive data_out=shreg[PAT_W-1], drive step=1, increment mealy_count if z_mealy=1, and go to WAIT.
REQ-024 SHALL, in WAIT, hold data_out, drive step=0, increment moore_count if z_moore=1, shift shreg left by 1, and decrement bitcnt.
REQ-025 SHALL leave WAIT for DONE when the decremented bitcnt=0, otherwise for SHIFT.
REQ-026 SHALL drive done=1 for the single DONE cycle, update mismatch registered at DONE entry, and return to IDLE.
REQ-027 SHALL produce step only in SHIFT, so each bit occupies exactly 2 cycles; done SHALL assert in cycle 2L+2 after the start-sampling edge (L = effective length).
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL, on abort=1 in LOAD, SHIFT or WAIT, go to IDLE next edge with no done pulse; counts SHALL be retained and mismatch SHALL stay 0.
REQ-030 SHALL give abort priority over a simultaneous transition to DONE; abort in DONE or IDLE SHALL have no effect.
REQ-031 SHALL never wrap the counts; CNT_W SHALL be sufficient for PAT_W detections.
REQ-032 SHALL hold data_out=0 in IDLE, LOAD and DONE.
REQ-033 SHALL hold counts and mismatch stable in IDLE until the next accepted start.

Reset
REQ-034 SHALL, while reset=0, asynchronously force state=IDLE, shreg=0, bitcnt=0, data_out=0, step=0, det_clr=0, busy=0, done=0, both counts=0 and mismatch=0.
REQ-035 SHALL, on reset assertion mid-run, abandon the run immediately with no done pulse.
REQ-036 SHALL accept start on the first clk edge after reset deasserts.

Verification
REQ-037 SHALL cover: pattern=16'hB000, length=4, z inputs 0 -> det_clr in cycle 1; data_out 1,0,1,1 with step in cycles 2,4,6,8; done in cycle 10; counts 0; mismatch 0.
REQ-038 SHALL cover: length=4, bench z_mealy=1 in SHIFT of bits 2 and 4, z_moore=1 in WAIT of bit 4 only -> mealy_count=2, moore_count=1, mismatch=1 at done.
REQ-039 SHALL cover: length=0 -> LOAD then DONE, zero step pulses, done in cycle 2.
REQ-040 SHALL cover: length=20 with PAT_W=16 -> exactly 16 step pulses, done in cycle 34.
REQ-041 SHALL cover: abort asserted in the WAIT of bit 2 -> IDLE next cycle, no done, busy=0; start re-pulsed while busy is ignored.
REQ-042 SHALL cover: reset pulled low in SHIFT of bit 3 -> all outputs 0 immediately, before the next clk edge.
